// File: rtl/xfer_bus_pkg.sv
// Shared types and helpers for the multidrop transfer bus.
package xfer_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        COMMIT = 2'd2
    } xfer_state_t;

    localparam int unsigned XFER_CNT_W = 16;

    // A command is dropped when it writes nothing or names a register that does not exist.
    function automatic logic cmd_dropped(input logic        mask_empty,
                                         input logic        src_ext,
                                         input int unsigned src_idx,
                                         input int unsigned num_regs);
        return mask_empty || (!src_ext && (src_idx >= num_regs));
    endfunction

endpackage

// File: rtl/bus_reg_slice.sv
// One bus-attached register: async active-low clear, load enable.
module bus_reg_slice #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_q <= '0;
        else if (load)
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/multidrop_xfer_bus.sv
// Multidrop register bus with IDLE->LATCH->COMMIT transfer sequencer.
// Optional commit counter on xfer_count when XFER_BUS_STATS_EN is defined.
module multidrop_xfer_bus
    import xfer_bus_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_src_ext,
    input  logic [IDX_W-1:0]             cmd_src_idx,
    input  logic [NUM_REGS-1:0]          cmd_dst_mask,
    input  logic [DATA_W-1:0]            data_in,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [DATA_W-1:0]            bus_q,
    output logic                         xfer_done,
`ifdef XFER_BUS_STATS_EN
    output logic                         cmd_err,
    output logic [XFER_CNT_W-1:0]        xfer_count
`else
    output logic                         cmd_err
`endif
);

    xfer_state_t         r_state;
    xfer_state_t         w_next;
    logic                r_src_ext;
    logic [IDX_W-1:0]    r_src_idx;
    logic [NUM_REGS-1:0] r_mask;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_bus_q;
    logic                r_xfer_done;
    logic                r_cmd_err;
    logic                w_accept;
    logic                w_drop;
    logic [DATA_W-1:0]   w_src_word;
    logic [DATA_W-1:0]   w_regs [NUM_REGS];

    assign w_accept = cmd_valid && cmd_ready;
    assign w_drop   = cmd_dropped(cmd_dst_mask == '0, cmd_src_ext,
                                  int'(cmd_src_idx), NUM_REGS);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !w_drop)
                    w_next = LATCH;
            end
            LATCH:   w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_src_ext <= 1'b0;
            r_src_idx <= '0;
            r_mask    <= '0;
            r_data    <= '0;
        end else if (w_accept) begin
            r_src_ext <= cmd_src_ext;
            r_src_idx <= cmd_src_idx;
            r_mask    <= cmd_dst_mask;
            r_data    <= data_in;
        end
    end

    // Index compare loop keeps the read in range for non-power-of-two NUM_REGS.
    always_comb begin
        w_src_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_src_idx == IDX_W'(i))
                w_src_word = w_regs[i];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_bus_q     <= '0;
            r_xfer_done <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            if (r_state == LATCH)
                r_bus_q <= r_src_ext ? r_data : w_src_word;
            r_xfer_done <= (r_state == COMMIT);
            r_cmd_err   <= w_accept && w_drop;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        bus_reg_slice #(.DATA_W(DATA_W)) u_slice (
            .Clock (Clock),
            .Reset (Reset),
            .load  ((r_state == COMMIT) && r_mask[g]),
            .d     (r_bus_q),
            .q     (w_regs[g])
        );
        assign regs_flat[g*DATA_W +: DATA_W] = w_regs[g];
    end

    assign bus_q     = r_bus_q;
    assign xfer_done = r_xfer_done;
    assign cmd_err   = r_cmd_err;

`ifdef XFER_BUS_STATS_EN
    logic [XFER_CNT_W-1:0] r_xfer_count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_xfer_count <= '0;
        else if ((r_state == COMMIT) && (r_xfer_count != '1))
            r_xfer_count <= r_xfer_count + 1'b1;
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_multidrop_xfer_bus.sv
// Directed bench for multidrop_xfer_bus (DATA_W=16, NUM_REGS=4).
module tb_multidrop_xfer_bus;

    logic        Clock;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_src_ext;
    logic [1:0]  cmd_src_idx;
    logic [3:0]  cmd_dst_mask;
    logic [15:0] data_in;
    logic [63:0] regs_flat;
    logic [15:0] bus_q;
    logic        xfer_done;
    logic        cmd_err;
`ifdef XFER_BUS_STATS_EN
    logic [15:0] xfer_count;
`endif

    int vectors;
    int miscompares;

    multidrop_xfer_bus #(.DATA_W(16), .NUM_REGS(4)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src_ext  (cmd_src_ext),
        .cmd_src_idx  (cmd_src_idx),
        .cmd_dst_mask (cmd_dst_mask),
        .data_in      (data_in),
        .regs_flat    (regs_flat),
        .bus_q        (bus_q),
        .xfer_done    (xfer_done),
`ifdef XFER_BUS_STATS_EN
        .cmd_err      (cmd_err),
        .xfer_count   (xfer_count)
`else
        .cmd_err      (cmd_err)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Present a command once the sequencer is idle, return #1 after the accept edge.
    task automatic drive_cmd(input logic ext, input logic [1:0] idx,
                             input logic [3:0] mask, input logic [15:0] data);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL ready_wait: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
            miscompares++;
        end
        cmd_valid    = 1'b1;
        cmd_src_ext  = ext;
        cmd_src_idx  = idx;
        cmd_dst_mask = mask;
        cmd_data_set(data);
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_data_set(input logic [15:0] data);
        data_in = data;
    endtask

    task automatic test_reset;
        Reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_src_ext  = 1'b0;
        cmd_src_idx  = 2'd0;
        cmd_dst_mask = 4'b0000;
        data_in      = 16'h0000;
        #1;
        vectors++;
        if (regs_flat !== 64'h0) begin
            $display("FAIL reset_regs: got %h required 0", regs_flat); miscompares++;
        end
        vectors++;
        if (bus_q !== 16'h0) begin
            $display("FAIL reset_bus: got %h required 0", bus_q); miscompares++;
        end
        vectors++;
        if (cmd_ready !== 1'b1 || xfer_done !== 1'b0 || cmd_err !== 1'b0) begin
            $display("FAIL reset_ctrl: ready=%b done=%b err=%b required 1 0 0",
                     cmd_ready, xfer_done, cmd_err);
            miscompares++;
        end
`ifdef XFER_BUS_STATS_EN
        vectors++;
        if (xfer_count !== 16'd0) begin
            $display("FAIL reset_count: got %0d required 0", xfer_count); miscompares++;
        end
`endif
        #11 Reset = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_ext_single;
        drive_cmd(1'b1, 2'd0, 4'b0001, 16'h0008);
        data_in = 16'hFFFF;
        vectors++;
        if (cmd_ready !== 1'b0 || xfer_done !== 1'b0) begin
            $display("FAIL single_t0: ready=%b done=%b required 0 0", cmd_ready, xfer_done);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (bus_q !== 16'h0008 || regs_flat !== 64'h0) begin
            $display("FAIL single_t1: bus=%h regs=%h required 0008 0", bus_q, regs_flat);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'h0000_0000_0000_0008) begin
            $display("FAIL single_regs: got %h required 0000000000000008", regs_flat);
            miscompares++;
        end
        vectors++;
        if (xfer_done !== 1'b1 || cmd_ready !== 1'b1) begin
            $display("FAIL single_done: done=%b ready=%b required 1 1", xfer_done, cmd_ready);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (xfer_done !== 1'b0) begin
            $display("FAIL single_pulse: done=%b required 0", xfer_done); miscompares++;
        end
    endtask

    task automatic test_ext_multidrop;
        drive_cmd(1'b1, 2'd2, 4'b1110, 16'hBEEF);
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'h0000_0000_0000_0008 || bus_q !== 16'hBEEF) begin
            $display("FAIL multi_t1: regs=%h bus=%h required 0000000000000008 BEEF",
                     regs_flat, bus_q);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'hBEEF_BEEF_BEEF_0008 || xfer_done !== 1'b1) begin
            $display("FAIL multi_regs: regs=%h done=%b required BEEFBEEFBEEF0008 1",
                     regs_flat, xfer_done);
            miscompares++;
        end
    endtask

    task automatic test_reg_move;
        drive_cmd(1'b0, 2'd3, 4'b1001, 16'h5555);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL move_busy0: ready=%b required 0", cmd_ready); miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (cmd_ready !== 1'b0 || bus_q !== 16'hBEEF) begin
            $display("FAIL move_t1: ready=%b bus=%h required 0 BEEF", cmd_ready, bus_q);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'hBEEF_BEEF_BEEF_BEEF || cmd_ready !== 1'b1 || xfer_done !== 1'b1) begin
            $display("FAIL move_regs: regs=%h ready=%b done=%b required BEEFBEEFBEEFBEEF 1 1",
                     regs_flat, cmd_ready, xfer_done);
            miscompares++;
        end
    endtask

    task automatic test_empty_mask;
        drive_cmd(1'b1, 2'd0, 4'b0000, 16'h7777);
        vectors++;
        if (cmd_err !== 1'b1 || cmd_ready !== 1'b1 || xfer_done !== 1'b0) begin
            $display("FAIL empty_t0: err=%b ready=%b done=%b required 1 1 0",
                     cmd_err, cmd_ready, xfer_done);
            miscompares++;
        end
        @(posedge Clock); #1;
        vectors++;
        if (cmd_err !== 1'b0 || xfer_done !== 1'b0 || bus_q !== 16'hBEEF
            || regs_flat !== 64'hBEEF_BEEF_BEEF_BEEF) begin
            $display("FAIL empty_t1: err=%b done=%b bus=%h regs=%h required 0 0 BEEF BEEFBEEFBEEFBEEF",
                     cmd_err, xfer_done, bus_q, regs_flat);
            miscompares++;
        end
`ifdef XFER_BUS_STATS_EN
        vectors++;
        if (xfer_count !== 16'd3) begin
            $display("FAIL count_three: got %0d required 3", xfer_count); miscompares++;
        end
`endif
    endtask

    task automatic test_back_to_back;
        // valid stays high: second command must not be taken until the sequencer is idle again
        drive_cmd(1'b1, 2'd0, 4'b0001, 16'h00A5);
        cmd_valid    = 1'b1;
        cmd_dst_mask = 4'b0010;
        data_in      = 16'h5A00;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'hBEEF_BEEF_BEEF_00A5 || xfer_done !== 1'b1 || cmd_ready !== 1'b1) begin
            $display("FAIL b2b_first: regs=%h done=%b ready=%b required BEEFBEEFBEEF00A5 1 1",
                     regs_flat, xfer_done, cmd_ready);
            miscompares++;
        end
        @(posedge Clock); #1;
        cmd_valid = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL b2b_accept: ready=%b required 0", cmd_ready); miscompares++;
        end
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        vectors++;
        if (regs_flat !== 64'hBEEF_BEEF_5A00_00A5 || xfer_done !== 1'b1) begin
            $display("FAIL b2b_second: regs=%h done=%b required BEEFBEEF5A0000A5 1",
                     regs_flat, xfer_done);
            miscompares++;
        end
`ifdef XFER_BUS_STATS_EN
        vectors++;
        if (xfer_count !== 16'd5) begin
            $display("FAIL count_five: got %0d required 5", xfer_count); miscompares++;
        end
`endif
    endtask

    task automatic test_reset_midxfer;
        int done_seen;
        drive_cmd(1'b1, 2'd0, 4'b1111, 16'h1234);
        Reset = 1'b0;
        #1;
        vectors++;
        if (regs_flat !== 64'h0 || bus_q !== 16'h0 || cmd_ready !== 1'b1) begin
            $display("FAIL midrst_clear: regs=%h bus=%h ready=%b required 0 0 1",
                     regs_flat, bus_q, cmd_ready);
            miscompares++;
        end
        @(posedge Clock); #2;
        Reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            if (xfer_done === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0 || regs_flat !== 64'h0 || cmd_ready !== 1'b1) begin
            $display("FAIL midrst_after: done_pulses=%0d regs=%h ready=%b required 0 0 1",
                     done_seen, regs_flat, cmd_ready);
            miscompares++;
        end
`ifdef XFER_BUS_STATS_EN
        vectors++;
        if (xfer_count !== 16'd0) begin
            $display("FAIL count_reset: got %0d required 0", xfer_count); miscompares++;
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_ext_single;
        test_ext_multidrop;
        test_reg_move;
        test_empty_mask;
        test_back_to_back;
        test_reset_midxfer;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
